// File: rtl/pong_graphics.sv
// Pong game-state and pixel-colour generator: paddles, ball, scores and FSM update once per frame.
// Optional build macro PONG_ROUND_BALL_EN draws the ball through an 8x8 round ROM mask.
module pong_graphics (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        l_up,
  input  logic        l_dn,
  input  logic        r_up,
  input  logic        r_dn,
  input  logic        serve,
  output logic [11:0] rgb,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_PAUSE, S_OVER} state_t;

  localparam logic [9:0] BALL_X0 = 10'd316;
  localparam logic [9:0] BALL_Y0 = 10'd236;
  localparam logic [9:0] PAD_Y0  = 10'd204;
  localparam logic [9:0] PAD_MIN = 10'd8;
  localparam logic [9:0] PAD_MAX = 10'd400;

  state_t      state_q, state_d;
  logic [9:0]  lp_y_q, lp_y_d, rp_y_q, rp_y_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d, srv_neg_q, srv_neg_d;
  logic [5:0]  pcnt_q, pcnt_d;
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic        match_q, match_d;
  logic [11:0] rgb_q, rgb_d;

  logic        frame_tick, ball_vis;
  logic        miss_l, miss_r, miss, hit_l, hit_r, win, dx_new, dy_new;
  logic [9:0]  bx7, by7;
  logic [3:0]  score_inc;

  function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn)      r = (y <= PAD_MIN + 10'd4) ? PAD_MIN : y - 10'd4;
    else if (dn && !up) r = (y >= PAD_MAX - 10'd4) ? PAD_MAX : y + 10'd4;
    return r;
  endfunction

  // pixel_x==0 is held for 4 clk, so only the first matching clk ticks
  assign match_d    = (pixel_y == 10'd481) && (pixel_x == 10'd0);
  assign frame_tick = match_d && !match_q;

  assign bx7    = bx_q + 10'd7;
  assign by7    = by_q + 10'd7;
  assign miss_l = dx_neg_q && (bx_q <= 10'd3);
  assign miss_r = !dx_neg_q && (bx7 >= 10'd636);
  assign miss   = miss_l || miss_r;
  assign hit_l  = dx_neg_q && (bx_q >= 10'd32) && (bx_q <= 10'd35) &&
                  (by7 >= lp_y_q) && (by_q <= lp_y_q + 10'd71);
  assign hit_r  = !dx_neg_q && (bx7 >= 10'd600) && (bx7 <= 10'd603) &&
                  (by7 >= rp_y_q) && (by_q <= rp_y_q + 10'd71);
  assign dy_new = (by_q <= 10'd8) ? 1'b0 : (by7 >= 10'd471) ? 1'b1 : dy_neg_q;
  assign dx_new = hit_l ? 1'b0 : hit_r ? 1'b1 : dx_neg_q;
  assign score_inc = miss_l ? score_r_q + 4'd1 : score_l_q + 4'd1;
  assign win       = (score_inc == 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_SERVE;
      lp_y_q    <= PAD_Y0;
      rp_y_q    <= PAD_Y0;
      bx_q      <= BALL_X0;
      by_q      <= BALL_Y0;
      dx_neg_q  <= 1'b0;
      dy_neg_q  <= 1'b0;
      srv_neg_q <= 1'b0;
      pcnt_q    <= 6'd0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      match_q   <= 1'b0;
      rgb_q     <= 12'h000;
    end else begin
      state_q   <= state_d;
      lp_y_q    <= lp_y_d;
      rp_y_q    <= rp_y_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      srv_neg_q <= srv_neg_d;
      pcnt_q    <= pcnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      match_q   <= match_d;
      rgb_q     <= rgb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        S_SERVE: if (serve) state_d = S_PLAY;
        S_PLAY:  if (miss) state_d = win ? S_OVER : S_PAUSE;
        S_PAUSE: if (pcnt_q == 6'd59) state_d = S_SERVE;
        S_OVER:  if (serve) state_d = S_SERVE;
        default: state_d = S_SERVE;
      endcase
    end
  end

  always_comb begin
    game_over = (state_q == S_OVER);
    ball_vis  = (state_q == S_SERVE) || (state_q == S_PLAY);
  end

  always_comb begin
    lp_y_d    = lp_y_q;
    rp_y_d    = rp_y_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    srv_neg_d = srv_neg_q;
    pcnt_d    = pcnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    if (frame_tick) begin
      case (state_q)
        S_SERVE: begin
          lp_y_d = pad_next(lp_y_q, l_up, l_dn);
          rp_y_d = pad_next(rp_y_q, r_up, r_dn);
          bx_d   = BALL_X0;
          by_d   = BALL_Y0;
          if (serve) begin
            dx_neg_d = srv_neg_q;
            dy_neg_d = 1'b0;
          end
        end
        S_PLAY: begin
          lp_y_d = pad_next(lp_y_q, l_up, l_dn);
          rp_y_d = pad_next(rp_y_q, r_up, r_dn);
          if (miss) begin
            // the side that missed serves next, toward itself
            if (miss_l) score_r_d = score_inc;
            else        score_l_d = score_inc;
            srv_neg_d = miss_l;
            bx_d      = BALL_X0;
            by_d      = BALL_Y0;
            pcnt_d    = 6'd0;
          end else begin
            dx_neg_d = dx_new;
            dy_neg_d = dy_new;
            bx_d     = dx_new ? bx_q - 10'd2 : bx_q + 10'd2;
            by_d     = dy_new ? by_q - 10'd2 : by_q + 10'd2;
          end
        end
        S_PAUSE: pcnt_d = pcnt_q + 6'd1;
        S_OVER: begin
          if (serve) begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            lp_y_d    = PAD_Y0;
            rp_y_d    = PAD_Y0;
            srv_neg_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic in_ball, ball_px, lpad_px, rpad_px, wall_px;

  assign in_ball = ball_vis && (pixel_x >= bx_q) && (pixel_x <= bx7) &&
                   (pixel_y >= by_q) && (pixel_y <= by7);

`ifdef PONG_ROUND_BALL_EN
  function automatic logic [7:0] ball_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: ball_row = 8'h3C;
      3'd1, 3'd6: ball_row = 8'h7E;
      default:    ball_row = 8'hFF;
    endcase
  endfunction

  logic [2:0] ball_col, ball_rw;
  logic [7:0] ball_bits;
  assign ball_col  = pixel_x[2:0] - bx_q[2:0];
  assign ball_rw   = pixel_y[2:0] - by_q[2:0];
  assign ball_bits = ball_row(ball_rw);
  assign ball_px   = in_ball && ball_bits[3'd7 - ball_col];
`else
  assign ball_px = in_ball;
`endif

  assign lpad_px = (pixel_x >= 10'd32) && (pixel_x <= 10'd35) &&
                   (pixel_y >= lp_y_q) && (pixel_y <= lp_y_q + 10'd71);
  assign rpad_px = (pixel_x >= 10'd600) && (pixel_x <= 10'd603) &&
                   (pixel_y >= rp_y_q) && (pixel_y <= rp_y_q + 10'd71);
  assign wall_px = (pixel_y <= 10'd7) || ((pixel_y >= 10'd472) && (pixel_y <= 10'd479));

  always_comb begin
    rgb_d = 12'h000;
    if (video_on) begin
      if (ball_px)      rgb_d = 12'hF00;
      else if (lpad_px) rgb_d = 12'h0F0;
      else if (rpad_px) rgb_d = 12'h00F;
      else if (wall_px) rgb_d = 12'hFFF;
    end
  end

  assign rgb     = rgb_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_graphics.sv
// Directed bench for pong_graphics: frames are emulated by pulsing the (481,0) scan position,
// and hidden state is observed by probing pixel colours.
module tb_pong_graphics;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        video_on = 1'b0;
  logic        l_up = 1'b0, l_dn = 1'b0, r_up = 1'b0, r_dn = 1'b0, serve = 1'b0;
  logic [11:0] rgb;
  logic [3:0]  score_l, score_r;
  logic        game_over;
  int          n_chk = 0, n_pass = 0;

  pong_graphics dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn), .serve(serve),
    .rgb(rgb), .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic frame();
    @(negedge clk);
    pixel_y = 10'd481; pixel_x = 10'd0; video_on = 1'b0;
    repeat (4) @(negedge clk);
    pixel_x = 10'd1;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic look(input int x, input int y);
    @(negedge clk);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    {l_up, l_dn, r_up, r_dn, serve} = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (rgb !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", rgb); else n_pass++;
    n_chk++; if ({score_l, score_r, game_over} !== 9'd0)
      $display("FAIL reset_out got=%h/%h/%b exp=0/0/0", score_l, score_r, game_over); else n_pass++;
    reset_n = 1'b1;
    frame();
    look(318, 238); n_chk++; if (rgb !== 12'hF00) $display("FAIL init_ball got=%h exp=F00", rgb); else n_pass++;
    look(33, 210);  n_chk++; if (rgb !== 12'h0F0) $display("FAIL init_lpad got=%h exp=0F0", rgb); else n_pass++;
    look(601, 210); n_chk++; if (rgb !== 12'h00F) $display("FAIL init_rpad got=%h exp=00F", rgb); else n_pass++;
    look(100, 3);   n_chk++; if (rgb !== 12'hFFF) $display("FAIL init_wall got=%h exp=FFF", rgb); else n_pass++;
    look(100, 475); n_chk++; if (rgb !== 12'hFFF) $display("FAIL init_wall_bot got=%h exp=FFF", rgb); else n_pass++;
    look(300, 100); n_chk++; if (rgb !== 12'h000) $display("FAIL init_bg got=%h exp=000", rgb); else n_pass++;
    @(negedge clk); pixel_x = 10'd318; pixel_y = 10'd238; video_on = 1'b0; @(negedge clk);
    n_chk++; if (rgb !== 12'h000) $display("FAIL blank got=%h exp=000", rgb); else n_pass++;
    n_chk++; if ({score_l, score_r, game_over} !== 9'd0)
      $display("FAIL init_score got=%h/%h/%b exp=0/0/0", score_l, score_r, game_over); else n_pass++;
  endtask

  task automatic test_paddle();
    do_reset();
    l_up = 1'b1; frames(10); l_up = 1'b0;
    look(33, 164); n_chk++; if (rgb !== 12'h0F0) $display("FAIL pad_164 got=%h exp=0F0", rgb); else n_pass++;
    look(33, 163); n_chk++; if (rgb !== 12'h000) $display("FAIL pad_163 got=%h exp=000", rgb); else n_pass++;
    l_up = 1'b1; frames(50); l_up = 1'b0;
    look(33, 8);  n_chk++; if (rgb !== 12'h0F0) $display("FAIL pad_sat_top got=%h exp=0F0", rgb); else n_pass++;
    look(33, 79); n_chk++; if (rgb !== 12'h0F0) $display("FAIL pad_sat_79 got=%h exp=0F0", rgb); else n_pass++;
    look(33, 80); n_chk++; if (rgb !== 12'h000) $display("FAIL pad_sat_80 got=%h exp=000", rgb); else n_pass++;
    l_up = 1'b1; l_dn = 1'b1; frames(5); l_up = 1'b0; l_dn = 1'b0;
    look(33, 8);  n_chk++; if (rgb !== 12'h0F0) $display("FAIL pad_both_8 got=%h exp=0F0", rgb); else n_pass++;
    look(33, 80); n_chk++; if (rgb !== 12'h000) $display("FAIL pad_both_80 got=%h exp=000", rgb); else n_pass++;
    l_dn = 1'b1; frame(); l_dn = 1'b0;
    look(33, 11); n_chk++; if (rgb !== 12'h000) $display("FAIL pad_dn_11 got=%h exp=000", rgb); else n_pass++;
    look(33, 83); n_chk++; if (rgb !== 12'h0F0) $display("FAIL pad_dn_83 got=%h exp=0F0", rgb); else n_pass++;
  endtask

  task automatic test_miss_pause();
    do_reset();
    serve = 1'b1; frame(); serve = 1'b0;
    frames(116);   // ball at (548,460), already bounced off the bottom
    look(551, 463); n_chk++; if (rgb !== 12'hF00) $display("FAIL bounce_ball got=%h exp=F00", rgb); else n_pass++;
    look(551, 468); n_chk++; if (rgb !== 12'h000) $display("FAIL bounce_below got=%h exp=000", rgb); else n_pass++;
    frames(41);    // ball at (630,378)
    look(633, 381); n_chk++; if (rgb !== 12'hF00) $display("FAIL edge_ball got=%h exp=F00", rgb); else n_pass++;
    n_chk++; if (score_l !== 4'd0) $display("FAIL pre_miss score_l=%0d exp=0", score_l); else n_pass++;
    frame();
    n_chk++; if (score_l !== 4'd1 || score_r !== 4'd0)
      $display("FAIL miss_score got=%0d/%0d exp=1/0", score_l, score_r); else n_pass++;
    look(319, 239); n_chk++; if (rgb !== 12'h000) $display("FAIL pause_hidden got=%h exp=000", rgb); else n_pass++;
    frames(59);
    look(319, 239); n_chk++; if (rgb !== 12'h000) $display("FAIL pause_59 got=%h exp=000", rgb); else n_pass++;
    frame();
    look(319, 239); n_chk++; if (rgb !== 12'hF00) $display("FAIL pause_60 got=%h exp=F00", rgb); else n_pass++;
  endtask

  task automatic test_paddle_hit();
    do_reset();
    r_dn = 1'b1; frames(39); r_dn = 1'b0;   // rp_y = 360
    look(601, 360); n_chk++; if (rgb !== 12'h00F) $display("FAIL rpad_360 got=%h exp=00F", rgb); else n_pass++;
    look(601, 359); n_chk++; if (rgb !== 12'h000) $display("FAIL rpad_359 got=%h exp=000", rgb); else n_pass++;
    serve = 1'b1; frame(); serve = 1'b0;
    frames(139);   // ball at (594,414), bx+7 = 601
    look(597, 417); n_chk++; if (rgb !== 12'hF00) $display("FAIL hit_pre got=%h exp=F00", rgb); else n_pass++;
    frame();       // bounced: ball at (592,412)
    look(593, 415); n_chk++; if (rgb !== 12'hF00) $display("FAIL hit_ball got=%h exp=F00", rgb); else n_pass++;
    look(601, 415); n_chk++; if (rgb !== 12'h00F) $display("FAIL hit_pad got=%h exp=00F", rgb); else n_pass++;
    frames(20);
    n_chk++; if (score_l !== 4'd0 || score_r !== 4'd0)
      $display("FAIL hit_noscore got=%0d/%0d exp=0/0", score_l, score_r); else n_pass++;
  endtask

  task automatic test_game_over();
    do_reset();
    r_dn = 1'b1; frames(39); r_dn = 1'b0;   // first rally bounces off the right paddle
    for (int i = 1; i <= 9; i++) begin
      serve = 1'b1; frame(); serve = 1'b0;
      for (int k = 0; k < 600 && score_r != 4'(i); k++) frame();
      n_chk++; if (score_r !== 4'(i) || score_l !== 4'd0)
        $display("FAIL over_miss%0d got=%0d/%0d exp=0/%0d", i, score_l, score_r, i); else n_pass++;
      if (i == 8) begin
        n_chk++; if (game_over !== 1'b0) $display("FAIL over_early got=%b exp=0", game_over); else n_pass++;
      end
      if (i < 9) frames(60);
    end
    n_chk++; if (game_over !== 1'b1) $display("FAIL over_flag got=%b exp=1", game_over); else n_pass++;
    look(319, 239); n_chk++; if (rgb !== 12'h000) $display("FAIL over_hidden got=%h exp=000", rgb); else n_pass++;
    frames(3);
    n_chk++; if (game_over !== 1'b1) $display("FAIL over_hold got=%b exp=1", game_over); else n_pass++;
    serve = 1'b1; frame(); serve = 1'b0;
    n_chk++; if ({score_l, score_r, game_over} !== 9'd0)
      $display("FAIL restart got=%0d/%0d/%b exp=0/0/0", score_l, score_r, game_over); else n_pass++;
    look(319, 239); n_chk++; if (rgb !== 12'hF00) $display("FAIL restart_ball got=%h exp=F00", rgb); else n_pass++;
    look(33, 204);  n_chk++; if (rgb !== 12'h0F0) $display("FAIL restart_lpad got=%h exp=0F0", rgb); else n_pass++;
    look(601, 204); n_chk++; if (rgb !== 12'h00F) $display("FAIL restart_rpad got=%h exp=00F", rgb); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    serve = 1'b1; frame(); serve = 1'b0;
    frames(158);   // right-side miss, now in PAUSE
    look(100, 3);
    n_chk++; if (rgb !== 12'hFFF || score_l !== 4'd1)
      $display("FAIL pre_rst got=%h/%0d exp=FFF/1", rgb, score_l); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (rgb !== 12'h000 || score_l !== 4'd0 || game_over !== 1'b0)
      $display("FAIL rst_pause got=%h/%0d/%b exp=000/0/0", rgb, score_l, game_over); else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    look(319, 239); n_chk++; if (rgb !== 12'hF00) $display("FAIL rst_pause_ball got=%h exp=F00", rgb); else n_pass++;
    serve = 1'b1; frame(); serve = 1'b0;
    frames(10);    // PLAY, ball at (336,256)
    look(319, 239); n_chk++; if (rgb !== 12'h000) $display("FAIL play_moved got=%h exp=000", rgb); else n_pass++;
    look(100, 3);
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (rgb !== 12'h000) $display("FAIL rst_play_rgb got=%h exp=000", rgb); else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    look(319, 239); n_chk++; if (rgb !== 12'hF00) $display("FAIL rst_play_ball got=%h exp=F00", rgb); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_miss_pause();
    test_paddle_hit();
    test_game_over();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pong_graphics.md
# pong_graphics

Game-state and pixel-colour generator for the 2-player pong design. Sits directly downstream of the VGA sync generator: consumes its `pixel_x`/`pixel_y`/`video_on` scan outputs plus player buttons, and updates paddles, ball, scores and game state once per frame. Drives the 12-bit RGB lines to the VGA connector.

## Interface
- No parameters; geometry is fixed below.
- `clk` in 1: 100 MHz system clock, same clock as the sync generator.
- `reset_n` in 1: asynchronous, active-low reset.
- `pixel_x` in 10: current scan column, 0–799. Each value is held for 4 clk.
- `pixel_y` in 10: current scan row, 0–524.
- `video_on` in 1: high inside the 640×480 visible area.
- `l_up`, `l_dn` in 1: left paddle up/down, level-sensitive, pre-debounced.
- `r_up`, `r_dn` in 1: right paddle up/down.
- `serve` in 1: serve/restart, level-sensitive.
- `rgb` out 12: {R[3:0],G[3:0],B[3:0]} pixel colour, registered.
- `score_l`, `score_r` out 4: scores, 0–9.
- `game_over` out 1: high in state OVER.

## Operation
- **frame_tick**: one-clk internal pulse on the first clk where `pixel_y==481 && pixel_x==0`, i.e. the previous clk did not match. All motion and FSM updates happen only on frame_tick.
- **Geometry**:
  - Walls: rows 0–7 and 472–479, full width.
  - Left paddle: columns 32–35, rows lp_y..lp_y+71.
  - Right paddle: columns 600–603, rows rp_y..rp_y+71.
  - Ball: 8×8 square with top-left corner at (bx,by).
- **Paddles**:
  - Move only in SERVE and PLAY.
  - On frame_tick, up alone moves y−4 and down alone moves y+4. Both pressed, or neither, means no move.
  - y is clamped to 8..400, saturating at the limit rather than wrapping.
- **Ball velocity** (PLAY only, evaluated on frame_tick from current positions):
  - dx, dy ∈ {−2,+2}.
  - `by<=8` → dy=+2.
  - `by+7>=471` → dy=−2.
  - Left paddle hit: dx<0, bx in 32..35, and `by+7>=lp_y && by<=lp_y+71` → dx=+2.
  - Right paddle hit: dx>0, bx+7 in 600..603, and rows overlap rp_y → dx=−2.
  - Position then updates with the new velocity: bx+=dx, by+=dy. Use 10-bit unsigned arithmetic; the miss checks below occur before any underflow.
- **Miss** (PLAY, on frame_tick):
  - `bx<=3 && dx<0` → score_r+1, next serve dx=−2.
  - `bx+7>=636 && dx>0` → score_l+1, next serve dx=+2.
  - Both conditions cannot occur together.
- **FSM states**: SERVE, PLAY, PAUSE, OVER.
  - SERVE: ball held at (316,236). `serve` sampled on frame_tick → PLAY with dy=+2 and the stored serve dx.
  - PLAY: on a miss, if the incremented score ==9 → OVER, else → PAUSE with frame counter cleared.
  - PAUSE: ball hidden; 6-bit frame counter counts frame_ticks; on the 60th → SERVE.
  - OVER: ball hidden, `game_over`=1. `serve` on frame_tick → both scores cleared, paddles set to 204, serve dx=+2 → SERVE.
- **Render priority**: ball > left paddle > right paddle > walls > background.
  - Colours: ball 12'hF00, left paddle 12'h0F0, right paddle 12'h00F, walls 12'hFFF, background 12'h000.
  - The ball is not drawn in PAUSE or OVER.
  - `video_on`=0 forces 12'h000.

## Timing
- `rgb` is registered: it reflects the inputs of the previous clk (1-clk latency). Pixel inputs are stable for 4 clk, so each pixel gets ≥3 valid output clks.
- State, positions and scores change only in the frame_tick cycle, during vertical blanking. No tearing.
- **Reset values** (asynchronous, `reset_n`=0):
  - `rgb`=0, `score_l`=`score_r`=0, `game_over`=0.
  - State SERVE; lp_y=rp_y=204; bx=316, by=236; serve dx=+2, dy=+2; pause counter 0.
- Reset mid-game returns immediately to these values, including when it occurs during PAUSE or OVER.
- frame_tick fires exactly once per 525-line frame, even though `pixel_x==0` is held for 4 clks.

## Configuration
- `PONG_ROUND_BALL_EN` defined: the ball uses an 8×8 ROM mask (rows 3C,7E,FF,FF,FF,FF,7E,3C). Only mask-1 pixels get ball colour; mask-0 pixels fall through to lower-priority layers.
- `PONG_ROUND_BALL_EN` undefined: the full 8×8 square is ball-coloured.
- Collision rules are identical in both builds.

## Test plan
- Reset then run 1 frame → rgb at (318,238) = 12'hF00, at (33,210) = 12'h0F0, at (100,3) = 12'hFFF, and 0 wherever video_on=0. State SERVE, scores 0.
- Hold l_up for 60 frames from lp_y=204 → lp_y decreases 4/frame and saturates at 8. Holding l_up and l_dn together → no change.
- Serve, no paddle input → dy flips +2→−2 when by+7 reaches 471, ball reaches right edge, score_l=1, state PAUSE. Exactly 60 frame_ticks later → SERVE, ball at (316,236).
- Right paddle at rp_y=200, ball arrives with bx+7=601 and by=240 → dx becomes −2 that frame, no score.
- Force 9 misses on the left player → score_r=9, game_over=1, ball not drawn. Assert serve → scores 0, game_over=0, SERVE.
- Assert reset_n=0 for one clk during PLAY → all outputs and state at reset values asynchronously, with no frame_tick required.
